dbus_uncached_axi: RTL and testbench

Responder (slave) end of the CPU uncached data bus. It accepts the core's uncached loads and stores and converts them into single-beat AXI4 transactions. Stores are posted through a small write buffer so they do not stall the pipeline. Loads stall the core until the write buffer has drained and the AXI read has completed, which preserves MMIO ordering. The block sits between the core's uncached dbus master port and the uncached AXI master port of the SoC interconnect.

---
 rtl/dbus_uncached_axi.sv | 199 +++++++++++++++++++
 tb/tb_dbus_uncached_axi.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_uncached_axi.sv
// Uncached dbus responder: posts stores through a small write buffer and turns
// loads/stores into single-beat AXI4 transactions, draining stores before loads.
module dbus_uncached_axi #(
  parameter int unsigned WBUF_DEPTH = 4,
  parameter logic [3:0]  AXI_ID     = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dbus_read,
  input  logic        dbus_write,
  input  logic [31:0] dbus_address,
  input  logic [3:0]  dbus_byteenable,
  input  logic [31:0] dbus_wrdata,
  output logic [31:0] dbus_rddata,
  output logic        dbus_stall,
  output logic        wbuf_empty,
  output logic        resp_err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam int unsigned PTR_W = $clog2(WBUF_DEPTH);
  localparam int unsigned CNT_W = $clog2(WBUF_DEPTH + 1);

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strb;
    logic [31:0] data;
  } wbuf_entry_t;

  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;
  typedef enum logic [2:0] {R_IDLE, R_DRAIN, R_ADDR, R_DATA, R_DONE} r_state_t;

  // Returns {size, addr[1:0]} for a byte-enable pattern.
  function automatic logic [4:0] size_lo(input logic [3:0] be);
    case (be)
      4'b0011: size_lo = {3'd1, 2'd0};
      4'b1100: size_lo = {3'd1, 2'd2};
      4'b0001: size_lo = {3'd0, 2'd0};
      4'b0010: size_lo = {3'd0, 2'd1};
      4'b0100: size_lo = {3'd0, 2'd2};
      4'b1000: size_lo = {3'd0, 2'd3};
      default: size_lo = {3'd2, 2'd0};
    endcase
  endfunction

  w_state_t          w_state, w_state_nxt;
  r_state_t          r_state, r_state_nxt;
  wbuf_entry_t       mem [WBUF_DEPTH];
  wbuf_entry_t       head, push_entry;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [4:0]        req_sl;
  logic [31:0]       ar_addr;
  logic [2:0]        ar_size;
  logic              push, pop, full, read_busy, aw_done, w_done, aw_fin, w_fin;
  logic              unused_bits;

  assign unused_bits = ^{dbus_address[1:0], rlast};

  assign req_sl     = size_lo(dbus_byteenable);
  assign push_entry = '{addr: {dbus_address[31:2], req_sl[1:0]}, size: req_sl[4:2],
                        strb: dbus_byteenable, data: dbus_wrdata};
  assign head       = mem[rd_ptr];
  assign full       = (count == CNT_W'(WBUF_DEPTH));
  assign pop        = bready && bvalid;
  assign push       = dbus_write && !read_busy && (!full || pop);
  assign count_nxt  = CNT_W'(count + CNT_W'(push) - CNT_W'(pop));
  assign wbuf_empty = (count == '0) && (w_state == W_IDLE);
  assign dbus_stall = read_busy || (dbus_write && full && !pop);
  assign aw_fin     = aw_done || (awvalid && awready);
  assign w_fin      = w_done || (wvalid && wready);

  // Buffer storage is not reset; payload outputs are gated by state instead.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (count != '0) w_state_nxt = W_SEND;
      W_SEND:  if (aw_fin && w_fin) w_state_nxt = W_RESP;
      W_RESP:  if (bvalid) w_state_nxt = (count_nxt != '0) ? W_SEND : W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    awvalid = (w_state == W_SEND) && !aw_done;
    wvalid  = (w_state == W_SEND) && !w_done;
    bready  = (w_state == W_RESP);
    awid    = AXI_ID;
    awlen   = 8'd0;
    awaddr  = '0;
    awsize  = '0;
    awburst = '0;
    wdata   = '0;
    wstrb   = '0;
    wlast   = 1'b0;
    if (w_state == W_SEND) begin
      awaddr  = head.addr;
      awsize  = head.size;
      awburst = 2'b01;
      wdata   = head.data;
      wstrb   = head.strb;
      wlast   = 1'b1;
    end
  end

  // A simultaneous write wins over a read; the read is not started.
  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (dbus_read && !dbus_write) r_state_nxt = wbuf_empty ? R_ADDR : R_DRAIN;
      R_DRAIN: if (wbuf_empty) r_state_nxt = R_ADDR;
      R_ADDR:  if (arready) r_state_nxt = R_DATA;
      R_DATA:  if (rvalid) r_state_nxt = R_DONE;
      R_DONE:  r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    arvalid   = (r_state == R_ADDR);
    rready    = (r_state == R_DATA);
    arburst   = (r_state == R_ADDR) ? 2'b01 : 2'b00;
    arid      = AXI_ID;
    arlen     = 8'd0;
    araddr    = ar_addr;
    arsize    = ar_size;
    read_busy = (r_state == R_DRAIN) || (r_state == R_ADDR) || (r_state == R_DATA) ||
                ((r_state == R_IDLE) && dbus_read && !dbus_write);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      ar_addr     <= '0;
      ar_size     <= '0;
      dbus_rddata <= '0;
      resp_err    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count   <= count_nxt;
      aw_done <= (w_state == W_SEND) && (w_state_nxt == W_SEND) && aw_fin;
      w_done  <= (w_state == W_SEND) && (w_state_nxt == W_SEND) && w_fin;
      if ((r_state == R_IDLE) && (r_state_nxt != R_IDLE)) begin
        ar_addr <= push_entry.addr;
        ar_size <= push_entry.size;
      end
      if (rvalid && rready) dbus_rddata <= rdata;
      resp_err <= (rvalid && rready && (rresp != 2'b00)) ||
                  (bvalid && bready && (bresp != 2'b00));
    end
  end

endmodule

// File: tb/tb_dbus_uncached_axi.sv
// Bench for dbus_uncached_axi: core driver, AXI responder model with
// per-channel delays, and scoreboard queues of expected AW/W/AR payloads.
module tb_dbus_uncached_axi;

  logic        clk = 1'b0;
  logic        rst;
  logic        dbus_read, dbus_write;
  logic [31:0] dbus_address, dbus_wrdata, dbus_rddata;
  logic [3:0]  dbus_byteenable;
  logic        dbus_stall, wbuf_empty, resp_err;
  logic [3:0]  arid, awid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  dbus_uncached_axi #(.WBUF_DEPTH(4), .AXI_ID(4'd0)) dut (
    .clk(clk), .rst(rst),
    .dbus_read(dbus_read), .dbus_write(dbus_write), .dbus_address(dbus_address),
    .dbus_byteenable(dbus_byteenable), .dbus_wrdata(dbus_wrdata),
    .dbus_rddata(dbus_rddata), .dbus_stall(dbus_stall), .wbuf_empty(wbuf_empty),
    .resp_err(resp_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {size, addr[1:0]} derived from the byte-enable pattern.
  function automatic logic [4:0] exp_sz(input logic [3:0] be);
    if (be == 4'b1111) return {3'd2, 2'd0};
    if (be == 4'b0011) return {3'd1, 2'd0};
    if (be == 4'b1100) return {3'd1, 2'd2};
    if ($countones(be) == 1)
      for (int i = 0; i < 4; i++) if (be[i]) return {3'd0, 2'(i)};
    return {3'd2, 2'd0};
  endfunction

  logic [34:0] exp_aw[$];
  logic [36:0] exp_w[$];
  logic [34:0] exp_ar[$];

  int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [31:0] r_data_cfg = '0;
  bit aw_out, w_out, r_out, ar_seen;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  int n_aw = 0, n_w = 0, n_b = 0, n_err = 0;

  task automatic slave_clear();
    awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
    rvalid = 0; rdata = 0; rresp = 0; rlast = 0;
    aw_out = 0; w_out = 0; r_out = 0; ar_seen = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    exp_aw.delete(); exp_w.delete(); exp_ar.delete();
  endtask

  // AXI responder: decides at each falling edge what the next rising edge sees.
  initial begin : axi_slave
    logic [34:0] e;
    logic [36:0] ew;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (resp_err) n_err++;
      if (bready) check_eq("bready_early", 64'(aw_out && w_out), 64'd1);
      if (aw_out && w_out) begin
        b_cnt++;
        bvalid = (b_cnt > b_delay);
        bresp  = bvalid ? b_resp_cfg : 2'b00;
      end else begin
        bvalid = 0; bresp = 0;
      end
      if (bvalid && bready) begin n_b++; aw_out = 0; w_out = 0; b_cnt = 0; end
      if (awvalid) begin aw_cnt++; awready = (aw_cnt > aw_delay); end
      else begin awready = 0; aw_cnt = 0; end
      if (awvalid && awready) begin
        check_eq("aw_dup", 64'(aw_out), 64'd0);
        if (exp_aw.size() == 0) check_eq("aw_unexpected", 64'(exp_aw.size()), 64'd1);
        else begin
          e = exp_aw.pop_front();
          check_eq("aw_payload", 64'({awaddr, awsize, awlen, awburst, awid}),
                   64'({e, 8'd0, 2'b01, 4'd0}));
        end
        aw_out = 1; n_aw++; aw_cnt = 0;
      end
      if (wvalid) begin w_cnt++; wready = (w_cnt > w_delay); end
      else begin wready = 0; w_cnt = 0; end
      if (wvalid && wready) begin
        check_eq("w_dup", 64'(w_out), 64'd0);
        if (exp_w.size() == 0) check_eq("w_unexpected", 64'(exp_w.size()), 64'd1);
        else begin
          ew = exp_w.pop_front();
          check_eq("w_payload", 64'({wdata, wstrb, wlast}), 64'(ew));
        end
        w_out = 1; n_w++; w_cnt = 0;
      end
      if (r_out) begin
        r_cnt++;
        rvalid = (r_cnt > r_delay);
        rdata  = rvalid ? r_data_cfg : 32'd0;
        rresp  = rvalid ? r_resp_cfg : 2'b00;
        rlast  = rvalid;
      end else begin
        rvalid = 0; rdata = 0; rresp = 0; rlast = 0;
      end
      if (rvalid && rready) begin r_out = 0; r_cnt = 0; end
      if (arvalid) begin
        if (!ar_seen) begin
          check_eq("ar_drained", 64'(exp_aw.size() + int'(aw_out) + int'(w_out)), 64'd0);
          ar_seen = 1;
        end
        ar_cnt++;
        arready = (ar_cnt > ar_delay);
      end else begin
        arready = 0; ar_cnt = 0;
      end
      if (arvalid && arready) begin
        if (exp_ar.size() == 0) check_eq("ar_unexpected", 64'(exp_ar.size()), 64'd1);
        else begin
          e = exp_ar.pop_front();
          check_eq("ar_payload", 64'({araddr, arsize, arlen, arburst, arid}),
                   64'({e, 8'd0, 2'b01, 4'd0}));
        end
        r_out = 1; ar_seen = 0; ar_cnt = 0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); #2;
    rst = 1; dbus_read = 0; dbus_write = 0;
    slave_clear();
    @(negedge clk); #2;
    rst = 0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                          output int stalls, output int b_at_accept);
    logic [4:0] sl;
    @(negedge clk);
    dbus_write = 1; dbus_address = a; dbus_byteenable = be; dbus_wrdata = d;
    stalls = 0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (!dbus_stall) break;
      stalls++;
      @(negedge clk);
    end
    check_eq("wr_accept", 64'(dbus_stall), 64'd0);
    b_at_accept = n_b;
    sl = exp_sz(be);
    exp_aw.push_back({a[31:2], sl[1:0], sl[4:2]});
    exp_w.push_back({d, be, 1'b1});
    @(posedge clk); #1;
    dbus_write = 0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                         input string tag);
    logic [4:0] sl;
    sl = exp_sz(be);
    exp_ar.push_back({a[31:2], sl[1:0], sl[4:2]});
    r_data_cfg = d;
    @(negedge clk);
    dbus_read = 1; dbus_address = a; dbus_byteenable = be;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (!dbus_stall) break;
      @(negedge clk);
    end
    check_eq({tag, "_done"}, 64'(dbus_stall), 64'd0);
    check_eq({tag, "_data"}, 64'(dbus_rddata), 64'(d));
    @(posedge clk); #1;
    dbus_read = 0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (wbuf_empty && exp_aw.size() == 0 && !aw_out && !w_out) break;
    end
    check_eq(tag, 64'(wbuf_empty), 64'd1);
  endtask

  task automatic check_quiet(input string tag);
    int busy;
    busy = 0;
    check_eq({tag, "_outs"}, 64'({arvalid, awvalid, wvalid, rready, bready, dbus_stall}), 64'd0);
    check_eq({tag, "_empty"}, 64'(wbuf_empty), 64'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (arvalid || awvalid || wvalid || rready || bready || dbus_stall) busy++;
    end
    check_eq({tag, "_traffic"}, 64'(busy), 64'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int st, bacc, nb0, aw0, w0, e0;
    rst = 1; dbus_read = 0; dbus_write = 0;
    dbus_address = '0; dbus_byteenable = '0; dbus_wrdata = '0;
    slave_clear();
    do_reset();
    #1;
    check_eq("rst_outs", 64'({arvalid, awvalid, wvalid, rready, bready, dbus_stall, resp_err}), 64'd0);
    check_eq("rst_rddata", 64'(dbus_rddata), 64'd0);
    check_eq("rst_empty", 64'(wbuf_empty), 64'd1);

    // Posted write with an always-ready memory
    do_write(32'h1FD0_F000, 4'b1111, 32'hDEAD_BEEF, st, bacc);
    check_eq("pw_stall", 64'(st), 64'd0);
    wait_idle("pw_empty");
    check_eq("pw_bcount", 64'(n_b), 64'd1);

    // Fill the buffer while B is held back
    b_delay = 10; nb0 = n_b; aw0 = n_aw; w0 = n_w;
    for (int i = 0; i < 5; i++) begin
      do_write(32'h1FD0_1000 + 32'(4 * i), 4'b1111, 32'hA000_0000 + 32'(i), st, bacc);
      if (i < 4) check_eq("full_nostall", 64'(st), 64'd0);
      else begin
        check_eq("full_stalled", 64'(st != 0), 64'd1);
        check_eq("full_push_on_b", 64'(bacc), 64'(nb0 + 1));
      end
    end
    wait_idle("full_empty");
    check_eq("full_aw_beats", 64'(n_aw - aw0), 64'd5);
    check_eq("full_w_beats", 64'(n_w - w0), 64'd5);

    // Load must wait for buffered stores
    b_delay = 3;
    do_write(32'h1FD0_0000, 4'b1111, 32'h1111_1111, st, bacc);
    do_write(32'h1FD0_0004, 4'b1111, 32'h2222_2222, st, bacc);
    do_read(32'h1FD0_0010, 4'b1111, 32'h1234_5678, "ord");

    // Sub-word sizing on both channels
    b_delay = 0;
    do_read(32'h1FC0_0001, 4'b0100, 32'h0000_00AB, "byte_ld");
    do_read(32'h1FC0_0005, 4'b1100, 32'hCAFE_0000, "half_ld");
    do_write(32'h1FC0_0010, 4'b1000, 32'h5500_0000, st, bacc);
    do_write(32'h1FC0_0020, 4'b0101, 32'h0066_0077, st, bacc);
    do_write(32'h1FC0_0030, 4'b0011, 32'h0000_8899, st, bacc);
    wait_idle("sub_empty");

    // W accepted well before AW, error response on B then on R
    aw_delay = 4; w_delay = 1; b_resp_cfg = 2'b10; e0 = n_err;
    do_write(32'h1FD0_2000, 4'b1111, 32'h0BAD_F00D, st, bacc);
    wait_idle("skew_empty");
    check_eq("skew_berr", 64'(n_err - e0), 64'd1);
    aw_delay = 0; w_delay = 0; b_resp_cfg = 2'b00;
    r_resp_cfg = 2'b10;
    do_read(32'h1FD0_3000, 4'b1111, 32'h7777_0001, "rerr");
    check_eq("rerr_count", 64'(n_err - e0), 64'd2);
    r_resp_cfg = 2'b00;

    // Reset while a read waits for data
    r_delay = 1000;
    exp_ar.push_back({30'(32'h1FD0_4000 >> 2), 2'd0, 3'd2});
    @(negedge clk);
    dbus_read = 1; dbus_address = 32'h1FD0_4000; dbus_byteenable = 4'b1111;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (rready) break;
    end
    check_eq("rdata_reached", 64'(rready), 64'd1);
    do_reset();
    r_delay = 0;
    #1;
    check_quiet("rst_rd");

    // Reset with stores still buffered
    b_delay = 1000;
    do_write(32'h1FD0_5000, 4'b1111, 32'h0000_0001, st, bacc);
    do_write(32'h1FD0_5004, 4'b1111, 32'h0000_0002, st, bacc);
    check_eq("rst_wr_buffered", 64'(wbuf_empty), 64'd0);
    do_reset();
    b_delay = 0;
    #1;
    check_quiet("rst_wr");

    // Post-reset sanity: a fresh write goes through normally
    do_write(32'h1FD0_6000, 4'b0010, 32'h0000_AB00, st, bacc);
    wait_idle("post_rst_empty");
    check_eq("sb_drained", 64'(exp_aw.size() + exp_w.size() + exp_ar.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
